// File: rtl/bit_erosion_detector.sv
// 3x3 binary erosion with its own line buffers and window generation.
// Ports: clk, rst_n, per_frame_{vsync,href,clken}, per_img_Bit in; post_* out.
// Fixed 3-clk latency; sync signals are delayed to stay aligned with data.
// Optional BIT_EROSION_BORDER_REPLICATE_EN: out-of-range taps read as 1.
module bit_erosion_detector #(
  parameter logic [9:0] IMG_HDISP = 10'd800,
  parameter logic [9:0] IMG_VDISP = 10'd600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic        per_img_Bit,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic        post_frame_clken,
  output logic        post_img_Bit,
  output logic [23:0] post_img
);

  localparam int DEPTH = int'(IMG_HDISP);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic       vs_q;
  logic       hr_q;
  logic       acc;
  logic       vrise;
  logic       hfall;
  logic [9:0] col;
  logic [9:0] row;
  logic       ovf;
  logic       lb1_vld;
  logic       lb2_vld;

  assign acc   = per_frame_clken & per_frame_href;
  assign vrise = per_frame_vsync & ~vs_q;
  assign hfall = ~per_frame_href & hr_q;

  // ovf marks pixels past the line end; col stays on the last column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q    <= 1'b0;
      hr_q    <= 1'b0;
      col     <= '0;
      row     <= '0;
      ovf     <= 1'b0;
      lb1_vld <= 1'b0;
      lb2_vld <= 1'b0;
    end else begin
      vs_q <= per_frame_vsync;
      hr_q <= per_frame_href;
      if (vrise) begin
        col     <= '0;
        row     <= '0;
        ovf     <= 1'b0;
        lb1_vld <= 1'b0;
        lb2_vld <= 1'b0;
      end else if (hfall) begin
        col     <= '0;
        ovf     <= 1'b0;
        row     <= (row != IMG_VDISP) ? row + 10'd1 : row;
        lb1_vld <= 1'b1;
        lb2_vld <= lb1_vld & (row != 10'd0);
      end else if (acc && !ovf) begin
        if (col == IMG_HDISP - 10'd1) begin
          ovf <= 1'b1;
        end else begin
          col <= col + 10'd1;
        end
      end
    end
  end

  logic          lb1 [DEPTH];
  logic          lb2 [DEPTH];
  logic [AW-1:0] addr;
  logic          rd1;
  logic          rd2;

  assign addr = col[AW-1:0];
  assign rd1  = lb1[addr];
  assign rd2  = lb2[addr];

  always_ff @(posedge clk) begin
    if (acc && !ovf) begin
      lb2[addr] <= lb1[addr];
      lb1[addr] <= per_img_Bit;
    end
  end

  // S0: window rows 0..2 = lines r-2, r-1, r; bit0 = newest column.
  logic [2:0] win [3];
  logic       rv1_r;
  logic       rv2_r;
  logic       cv1_r;
  logic       cv2_r;
  logic       ok_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win[0] <= '0;
      win[1] <= '0;
      win[2] <= '0;
      rv1_r  <= 1'b0;
      rv2_r  <= 1'b0;
      cv1_r  <= 1'b0;
      cv2_r  <= 1'b0;
      ok_r   <= 1'b0;
    end else if (acc) begin
      win[0] <= {win[0][1:0], rd2};
      win[1] <= {win[1][1:0], rd1};
      win[2] <= {win[2][1:0], per_img_Bit};
      rv1_r  <= lb1_vld;
      rv2_r  <= lb2_vld;
      cv1_r  <= (col != 10'd0);
      cv2_r  <= (col > 10'd1);
      ok_r   <= ~ovf;
    end
  end

  logic [2:0] vm  [3];
  logic [2:0] eff [3];

  always_comb begin
    vm[0] = {cv2_r, cv1_r, 1'b1} & {3{rv2_r}};
    vm[1] = {cv2_r, cv1_r, 1'b1} & {3{rv1_r}};
    vm[2] = {cv2_r, cv1_r, 1'b1};
    for (int i = 0; i < 3; i++) begin
`ifdef BIT_EROSION_BORDER_REPLICATE_EN
      eff[i] = win[i] | ~vm[i];
`else
      eff[i] = win[i] & vm[i];
`endif
    end
  end

  logic [2:0] acc_d;
  logic [2:0] vs_d;
  logic [2:0] hr_d;
  logic [2:0] ce_d;
  logic [2:0] row_and;
  logic       ok_s1;
  logic       bit_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_d   <= '0;
      vs_d    <= '0;
      hr_d    <= '0;
      ce_d    <= '0;
      row_and <= '0;
      ok_s1   <= 1'b0;
      bit_r   <= 1'b0;
    end else begin
      acc_d <= {acc_d[1:0], acc};
      vs_d  <= {vs_d[1:0], per_frame_vsync};
      hr_d  <= {hr_d[1:0], per_frame_href};
      ce_d  <= {ce_d[1:0], per_frame_clken};
      if (acc_d[0]) begin
        row_and <= {&eff[2], &eff[1], &eff[0]};
        ok_s1   <= ok_r;
      end
      if (acc_d[1]) begin
        bit_r <= (&row_and) & ok_s1;
      end
    end
  end

  assign post_frame_vsync = vs_d[2];
  assign post_frame_href  = hr_d[2];
  assign post_frame_clken = ce_d[2];
  assign post_img_Bit     = hr_d[2] & bit_r;
  assign post_img         = post_img_Bit ? 24'h000000 : 24'hFFFFFF;

endmodule

// File: tb/tb_bit_erosion_detector.sv
// Self-checking bench for bit_erosion_detector (8x6 image).
// Frame table + random frames, checked against a frame-array model.
module tb_bit_erosion_detector;

  localparam int H = 8;
`ifdef BIT_EROSION_BORDER_REPLICATE_EN
  localparam bit REPL = 1'b1;
`else
  localparam bit REPL = 1'b0;
`endif

  localparam int P_ALL = 0;
  localparam int P_ONE = 1;
  localparam int P_BLK = 2;
  localparam int P_OVL = 3;
  localparam int P_RND = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        per_frame_vsync = 1'b0;
  logic        per_frame_href = 1'b0;
  logic        per_frame_clken = 1'b0;
  logic        per_img_Bit = 1'b0;
  logic        post_frame_vsync;
  logic        post_frame_href;
  logic        post_frame_clken;
  logic        post_img_Bit;
  logic [23:0] post_img;

  bit_erosion_detector #(
    .IMG_HDISP(10'd8),
    .IMG_VDISP(10'd6)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .per_frame_vsync(per_frame_vsync),
    .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken),
    .per_img_Bit(per_img_Bit),
    .post_frame_vsync(post_frame_vsync),
    .post_frame_href(post_frame_href),
    .post_frame_clken(post_frame_clken),
    .post_img_Bit(post_img_Bit),
    .post_img(post_img)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit vs;
    bit hr;
    bit ce;
    bit b;
    int r;
    int c;
  } exp_t;

  typedef struct {
    string name;
    int    pat;
    int    ones_def;
    int    ones_rep;
  } vec_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   ones = 0;
  int   last_r = -1;
  int   last_c = -1;

  int   mr = 0;
  int   mc = 0;
  bit   pvs = 0;
  bit   phr = 0;
  bit   held = 0;
  bit   img [64][16];

  task automatic fail(input string n, input logic [23:0] got,
                      input logic [23:0] want);
    miscompares++;
    $display("FAIL %s: got %h want %h at %0t", n, got, want, $time);
  endtask

  task automatic check_val(input string n, input logic [23:0] got,
                           input logic [23:0] want);
    vectors++;
    if (got !== want) fail(n, got, want);
  endtask

  function automatic bit tap(input int i, input int j);
    if (i < 0 || j < 0) return REPL;
    if (i > 63 || j > 15) return 1'b0;
    return img[i][j];
  endfunction

  task automatic check_out(input exp_t e);
    logic [23:0] wi;
    wi = e.b ? 24'h000000 : 24'hFFFFFF;
    vectors++;
    if (post_frame_vsync !== e.vs) fail("vsync", post_frame_vsync, e.vs);
    if (post_frame_href !== e.hr) fail("href", post_frame_href, e.hr);
    if (post_frame_clken !== e.ce) fail("clken", post_frame_clken, e.ce);
    if (post_img_Bit !== e.b) fail("bit", post_img_Bit, e.b);
    if (post_img !== wi) fail("img", post_img, wi);
    if (e.hr && e.ce && post_img_Bit === 1'b1) begin
      ones++;
      last_r = e.r;
      last_c = e.c;
    end
  endtask

  task automatic cycle(input bit vs, input bit hr, input bit ce, input bit b);
    exp_t e;
    bit   acc;
    bit   vrise;
    bit   hfall;
    bit   res;
    @(negedge clk);
    if (q.size() >= 3) begin
      e = q.pop_front();
      check_out(e);
    end
    per_frame_vsync = vs;
    per_frame_href  = hr;
    per_frame_clken = ce;
    per_img_Bit     = b;
    acc   = hr & ce;
    vrise = vs & ~pvs;
    hfall = ~hr & phr;
    e.r = mr;
    e.c = mc;
    if (acc) begin
      if (mc >= H) begin
        res = 1'b0;
      end else begin
        if (mr < 64) img[mr][mc] = b;
        res = 1'b1;
        for (int di = 0; di < 3; di++)
          for (int dj = 0; dj < 3; dj++)
            res = res & tap(mr - di, mc - dj);
      end
      held = res;
      mc++;
    end
    if (vrise) begin
      mr = 0;
      mc = 0;
    end else if (hfall) begin
      mr++;
      mc = 0;
    end
    pvs  = vs;
    phr  = hr;
    e.vs = vs;
    e.hr = hr;
    e.ce = ce;
    e.b  = hr ? held : 1'b0;
    q.push_back(e);
  endtask

  function automatic bit pixel(input int pat, input int r, input int c);
    unique case (pat)
      P_ALL, P_OVL: return 1'b1;
      P_ONE: return (r == 3 && c == 3);
      P_BLK: return (r >= 2 && r <= 4 && c >= 2 && c <= 4);
      default: return ($urandom_range(0, 9) < 8);
    endcase
  endfunction

  task automatic drive_frame(input int pat, input bit gaps,
                             input int stop_r, input int stop_c);
    int len;
    repeat (2) cycle(1, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0);
    for (int r = 0; r < 6; r++) begin
      len = (pat == P_OVL && r == 3) ? 10 : H;
      for (int c = 0; c < len; c++) begin
        if (r == stop_r && c == stop_c) return;
        if (gaps)
          while ($urandom_range(0, 3) == 0)
            cycle(0, 1, 0, 1'($urandom_range(0, 1)));
        cycle(0, 1, 1, pixel(pat, r, c));
      end
      repeat (gaps ? $urandom_range(2, 4) : 2) cycle(0, 0, 0, 0);
    end
    repeat (4) cycle(0, 0, 0, 0);
  endtask

  task automatic model_reset();
    q.delete();
    mr   = 0;
    mc   = 0;
    pvs  = 0;
    phr  = 0;
    held = 0;
  endtask

  task automatic model_release();
    exp_t z;
    z = '{vs: 0, hr: 0, ce: 0, b: 0, r: 0, c: 0};
    repeat (3) q.push_back(z);
  endtask

  task automatic check_reset_outputs(input string n);
    check_val({n, "_vs"}, post_frame_vsync, 0);
    check_val({n, "_hr"}, post_frame_href, 0);
    check_val({n, "_ce"}, post_frame_clken, 0);
    check_val({n, "_bit"}, post_img_Bit, 0);
    check_val({n, "_img"}, post_img, 24'hFFFFFF);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [4];
    tbl[0] = '{name: "all1", pat: P_ALL, ones_def: 24, ones_rep: 48};
    tbl[1] = '{name: "single", pat: P_ONE, ones_def: 0, ones_rep: 0};
    tbl[2] = '{name: "block", pat: P_BLK, ones_def: 1, ones_rep: 1};
    tbl[3] = '{name: "overlong", pat: P_OVL, ones_def: 24, ones_rep: 48};

    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    model_release();

    for (int i = 0; i < 4; i++) begin
      ones = 0;
      last_r = -1;
      last_c = -1;
      drive_frame(tbl[i].pat, 1'b0, -1, -1);
      check_val({tbl[i].name, "_ones"}, ones,
                REPL ? tbl[i].ones_rep : tbl[i].ones_def);
      if (tbl[i].pat == P_BLK)
        check_val("block_pos", last_r * 100 + last_c, 404);
    end

    for (int f = 0; f < 15; f++) drive_frame(P_RND, 1'b1, -1, -1);

    for (int k = 0; k < 300; k++) begin
      bit vs;
      bit hr;
      vs = ($urandom_range(0, 3) == 0);
      hr = 1'($urandom_range(0, 1));
      cycle(vs, hr, hr ? 1'b0 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (4) cycle(0, 0, 0, 0);

    for (int f = 0; f < 3; f++) drive_frame(P_RND, 1'b1, -1, -1);

    drive_frame(P_ALL, 1'b0, 3, 4);
    @(negedge clk);
    rst_n = 1'b0;
    per_frame_vsync = 0;
    per_frame_href  = 0;
    per_frame_clken = 0;
    per_img_Bit     = 0;
    model_reset();
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    check_reset_outputs("midrst2");
    @(negedge clk);
    rst_n = 1'b1;
    model_release();
    repeat (5) cycle(0, 0, 0, 0);
    ones = 0;
    drive_frame(P_ALL, 1'b0, -1, -1);
    check_val("resync_ones", ones, REPL ? 48 : 24);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
